serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 9 +
 rtl/serial_subtractor_fs.sv | 11 +
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 122 ++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and counter sizing for the bit-serial subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int CNT_W = $clog2(DEF_WIDTH);
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: single-bit x - y - borrow cell, purely combinational
module full_subtractor (
    input  logic bit1,
    input  logic bit2,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = bit1 ^ bit2 ^ bin;
    assign bout = (~bit1 & bit2) | (~(bit1 ^ bit2) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             neg,
    output logic             ovf,
`endif
    output logic             bout
);
    localparam int CW = cnt_width(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic br, d, br_next, last;
`ifdef SERIAL_SUB_FLAGS_EN
    logic nz;
`endif
    full_subtractor u_fs (.bit1(a_sr[0]), .bit2(b_sr[0]), .bin(br), .diff(d), .bout(br_next));
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            nz        <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr     <= a;
                    b_sr     <= b;
                    br       <= bin;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                    nz       <= 1'b0;
`endif
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    diff <= {d, diff[WIDTH-1:1]};
                    cnt  <= last ? cnt : cnt + 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
                    nz   <= nz | d;
`endif
                    if (last) begin
                        bout      <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        // on the last bit the shift registers hold the operand MSBs
                        zero      <= ~(nz | d);
                        neg       <= d;
                        ovf       <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against a plain-arithmetic model
module tb_serial_subtractor;
    localparam int W = 32;
    logic clk = 0, rst = 0, in_valid = 0, in_ready, bin = 0, out_valid, out_ready = 0, bout;
    logic [W-1:0] a = '0, b = '0, diff;
`ifdef SERIAL_SUB_FLAGS_EN
    logic zero, neg, ovf;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero(zero), .neg(neg), .ovf(ovf),
`endif
        .bout(bout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int gap);
        int n = 0;
        repeat (gap) @(posedge clk);
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = av; b = bv; bin = bi; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; bin = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int gap, input int stall);
        logic [W:0] r;
        int k = 0;
        r = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
        send(av, bv, bi, gap);
        while (!out_valid && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("latency_edges", k, W);
        check("diff", diff, r[W-1:0]);
        check("bout", bout, r[W]);
        check("in_ready_done", in_ready, 0);
`ifdef SERIAL_SUB_FLAGS_EN
        check("zero", zero, r[W-1:0] == 0);
        check("neg", neg, r[W-1]);
        check("ovf", ovf, (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]));
`endif
        repeat (stall) @(posedge clk);
        #1;
        check("stall_valid", out_valid, 1);
        check("stall_diff", diff, r[W-1:0]);
        check("stall_in_ready", in_ready, 0);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("retire_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
        check("held_diff", diff, r[W-1:0]);
        check("held_bout", bout, r[W]);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] sp [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        return ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : W'($urandom);
    endfunction

    initial begin
        #1 rst = 1;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_FLAGS_EN
        check("rst_flags", {zero, neg, ovf}, 0);
`endif
        @(posedge clk); #1 rst = 0;

        run_op(32'd5, 32'd3, 1'b0, 0, 0);
        run_op(32'd3, 32'd5, 1'b0, 0, 0);
        run_op(32'd0, 32'd0, 1'b1, 0, 0);
        run_op(32'd0, 32'd1, 1'b0, 0, 10);
        // accept must land exactly one edge after retirement
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0, 0);
        run_op(32'h1234, 32'h1234, 1'b0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 3);

        send(32'd7, 32'd3, 1'b0, 0);
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        check("midrun_out_valid", out_valid, 0);
        check("midrun_in_ready", in_ready, 1);
        check("midrun_diff", diff, 0);
        @(posedge clk); #1 rst = 0;
        repeat (40) @(posedge clk);
        #1;
        check("no_spurious_valid", out_valid, 0);
        run_op(32'd100, 32'd1, 1'b0, 0, 0);

        for (int i = 0; i < 1000; i++)
            run_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
